// File: rtl/mux_bist_ctrl.sv
// BIST controller for a combinational 4:1 mux: drives patterns, compacts dut_y into an 8-bit SISR, compares to GOLDEN_SIG.
// Optional macro MUX_BIST_EXHAUSTIVE_EN replaces the LFSR pattern source with a 64-step binary counter.
module mux_bist_ctrl #(
  parameter int unsigned PAT_COUNT  = 63,
  parameter logic [5:0]  SEED       = 6'h01,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] test_i,
  output logic [1:0] test_s,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);

  typedef enum logic [1:0] {IDLE, RUN, COMPARE, DONE} state_t;

`ifdef MUX_BIST_EXHAUSTIVE_EN
  localparam logic [5:0] PAT_INIT = '0;
`else
  localparam logic [5:0] PAT_INIT = SEED;
  localparam logic [5:0] LAST_CNT = 6'(PAT_COUNT - 1);
`endif

  state_t     state_q, state_d;
  logic [5:0] src_q, src_d;
  logic [5:0] pat_q, pat_d;
  logic [7:0] sig_q, sig_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [5:0] src_next;
  logic       last_pat;

`ifdef MUX_BIST_EXHAUSTIVE_EN
  assign src_next = src_q + 6'd1;
  assign last_pat = (src_q == 6'h3f);
`else
  logic [5:0] cnt_q, cnt_d;
  assign src_next = {src_q[4:0], src_q[5] ^ src_q[4]};
  assign last_pat = (cnt_q == LAST_CNT);
`endif

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
`ifndef MUX_BIST_EXHAUSTIVE_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          src_d   = PAT_INIT;
          sig_d   = '0;
          pass_d  = 1'b0;
`ifndef MUX_BIST_EXHAUSTIVE_EN
          cnt_d   = '0;
`endif
        end
      end
      RUN: begin
        // Response of the pattern currently on the outputs is shifted on this edge.
        sig_d = {sig_q[6:0], sig_q[7] ^ sig_q[3] ^ sig_q[2] ^ sig_q[1] ^ dut_y};
        src_d = src_next;
`ifndef MUX_BIST_EXHAUSTIVE_EN
        cnt_d = cnt_q + 6'd1;
`endif
        if (last_pat) state_d = COMPARE;
      end
      COMPARE: begin
        pass_d  = (sig_q == GOLDEN_SIG);
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    pat_d  = (state_d == RUN) ? src_d : '0;
    busy_d = (state_d == RUN) || (state_d == COMPARE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= PAT_INIT;
      pat_q   <= '0;
      sig_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
`ifndef MUX_BIST_EXHAUSTIVE_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      pat_q   <= pat_d;
      sig_q   <= sig_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
`ifndef MUX_BIST_EXHAUSTIVE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign test_s    = pat_q[5:4];
  assign test_i    = pat_q[3:0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_mux_bist_ctrl.sv
// Self-checking bench for mux_bist_ctrl: fault-free mux run, random responses, stuck-at-0, abort/restart, start handling.
module tb_mux_bist_ctrl;

`ifdef MUX_BIST_EXHAUSTIVE_EN
  localparam bit EXH = 1'b1;
`else
  localparam bit EXH = 1'b0;
`endif

  function automatic logic [5:0] pat_at(input int k, input logic [5:0] seed);
    int p;
    if (EXH) return 6'(k);
    p = int'(seed);
    for (int n = 0; n < k; n++) p = ((p * 2) % 64) + (((p / 32) + (p / 16)) % 2);
    return 6'(p);
  endfunction

  function automatic logic [7:0] sig_step(input logic [7:0] s, input logic y);
    return {s[6:0], s[7] ^ s[3] ^ s[2] ^ s[1] ^ y};
  endfunction

  function automatic logic [7:0] fault_free_sig(input int n, input logic [5:0] seed);
    logic [7:0] s;
    logic [5:0] p;
    logic [3:0] d;
    logic [1:0] sel;
    s = '0;
    for (int k = 0; k < n; k++) begin
      p   = pat_at(k, seed);
      d   = p[3:0];
      sel = p[5:4];
      s   = sig_step(s, d[sel]);
    end
    return s;
  endfunction

  localparam int         N0      = EXH ? 64 : 63;
  localparam int         N1      = EXH ? 64 : 7;
  localparam logic [5:0] SEED1   = 6'h2B;
  localparam logic [7:0] GOLDEN1 = 8'h5C;
  localparam logic [7:0] GOLDEN0 = fault_free_sig(N0, 6'h01);

  logic       clk = 1'b0;
  logic       rst, start0, start1, y0, y1;
  logic [3:0] test_i0, test_i1;
  logic [1:0] test_s0, test_s1;
  logic       busy0, busy1, done0, done1, pass0, pass1;
  logic [7:0] sig0, sig1;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;

  assign y0 = test_i0[test_s0];

  mux_bist_ctrl #(.PAT_COUNT(63), .SEED(6'h01), .GOLDEN_SIG(GOLDEN0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .test_i(test_i0), .test_s(test_s0),
    .dut_y(y0), .busy(busy0), .done(done0), .pass(pass0), .signature(sig0)
  );

  mux_bist_ctrl #(.PAT_COUNT(7), .SEED(SEED1), .GOLDEN_SIG(GOLDEN1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .test_i(test_i1), .test_s(test_s1),
    .dut_y(y1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pat0"}, {26'd0, test_s0, test_i0}, 32'd0);
    chk({tag, "_ctl0"}, {29'd0, busy0, done0, pass0}, 32'd0);
    chk({tag, "_sig0"}, {24'd0, sig0}, 32'd0);
    chk({tag, "_pat1"}, {26'd0, test_s1, test_i1}, 32'd0);
    chk({tag, "_ctl1"}, {29'd0, busy1, done1, pass1}, 32'd0);
    chk({tag, "_sig1"}, {24'd0, sig1}, 32'd0);
  endtask

  // Runs dut0 against the real mux; abort_at >= 0 fires rst mid-cycle during that pattern.
  task automatic run0(input string tag, input bit hold, input int abort_at);
    int cyc;
    int seen [64];
    bit cover_ok;
    foreach (seen[i]) seen[i] = 0;
    start0 = 1'b1;
    tick();
    chk({tag, "_done_fell"}, {31'd0, done0}, 32'd0);
    chk({tag, "_busy_rose"}, {31'd0, busy0}, 32'd1);
    if (!hold) start0 = 1'b0;
    cyc = 0;
    while (busy0 === 1'b1 && cyc < 200) begin
      if (cyc == abort_at) begin
        #3 rst = 1'b1;
        start0 = 1'b0;
        #1 chk_reset({tag, "_abort"});
        @(negedge clk) rst = 1'b0;
        tick();
        return;
      end
      if (cyc < N0) begin
        chk({tag, "_pat"}, {26'd0, test_s0, test_i0}, {26'd0, pat_at(cyc, 6'h01)});
        seen[{test_s0, test_i0}]++;
      end else begin
        chk({tag, "_cmp_pat"}, {26'd0, test_s0, test_i0}, 32'd0);
      end
      tick();
      cyc++;
    end
    start0 = 1'b0;
    chk({tag, "_busy_len"}, cyc, N0 + 1);
    chk({tag, "_done"}, {31'd0, done0}, 32'd1);
    chk({tag, "_pass"}, {31'd0, pass0}, 32'd1);
    chk({tag, "_sig"}, {24'd0, sig0}, {24'd0, GOLDEN0});
    chk({tag, "_idle_pat"}, {26'd0, test_s0, test_i0}, 32'd0);
    cover_ok = 1'b1;
    for (int v = 0; v < 64; v++) if (seen[v] != ((EXH || v != 0) ? 1 : 0)) cover_ok = 1'b0;
    chk({tag, "_coverage"}, {31'd0, cover_ok}, 32'd1);
    tick();
    chk({tag, "_done_hold"}, {23'd0, done0, pass0, sig0}, {23'd0, 1'b1, 1'b1, GOLDEN0});
  endtask

  // Runs dut1 with random (or stuck-at-0) responses and a running signature model.
  task automatic run1(input string tag, input bit stuck);
    int cyc;
    logic [7:0] msig;
    msig = '0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    cyc = 0;
    while (busy1 === 1'b1 && cyc < 200) begin
      if (cyc < N1) begin
        chk({tag, "_pat"}, {26'd0, test_s1, test_i1}, {26'd0, pat_at(cyc, SEED1)});
        y1   = stuck ? 1'b0 : 1'($urandom);
        msig = sig_step(msig, y1);
      end else begin
        y1 = 1'b0;
      end
      tick();
      cyc++;
    end
    chk({tag, "_busy_len"}, cyc, N1 + 1);
    chk({tag, "_done"}, {31'd0, done1}, 32'd1);
    chk({tag, "_sig"}, {24'd0, sig1}, {24'd0, msig});
    chk({tag, "_pass"}, {31'd0, pass1}, {31'd0, msig == GOLDEN1});
    if (stuck) begin
      chk({tag, "_sig_zero"}, {24'd0, sig1}, 32'd0);
      chk({tag, "_fail_flag"}, {31'd0, pass1}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; y1 = 1'b0;
    #2 chk_reset("reset");
    @(negedge clk) rst = 1'b0;
    tick();
    chk_reset("idle");

    run0("clean", 1'b0, -1);
    repeat ($urandom_range(0, 5)) tick();
    run0("hold_start", 1'b1, -1);
    repeat ($urandom_range(0, 5)) tick();
    run0("abort", 1'b0, 20);
    chk_reset("post_abort");
    run0("restart", 1'b0, -1);

    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 4)) tick();
      run1("rand", 1'b0);
    end
    run1("stuck0", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
